// File: rtl/conv_batch_seq.sv
`default_nettype none
// ============================================================================
// conv_batch_seq : layer sequencer (weight load, batch streaming, completion irq)
// Rev 1.0 -- optional RUN-cycle counter enabled by CONV_SEQ_PERF_EN
// ============================================================================
module conv_batch_seq #(
   parameter int BW = 16,
   parameter int PW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [4:0]    cfg_out_ch,
   input  logic [8:0]    cfg_src_a_max,
   input  logic [8:0]    cfg_dst_a_max,
   input  logic [PW-1:0] cfg_prm_words,
   input  logic [BW-1:0] cfg_batches,
   input  logic          abort,
   output logic [4:0]    out_ch,
   output logic [8:0]    src_a_max,
   output logic [8:0]    dst_a_max,
   output logic          matw,
   output logic          run,
   output logic          last,
   input  logic          src_valid,
   input  logic          src_ready,
   input  logic          dst_valid,
   input  logic          dst_ready,
   output logic          busy,
   output logic          done,
   output logic          irq,
   input  logic          irq_clr,
   output logic [31:0]   perf_cycles
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WLOAD = 3'd1,
      S_GAP   = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    out_ch_q, out_ch_d;
   logic [8:0]    src_a_max_q, src_a_max_d;
   logic [8:0]    dst_a_max_q, dst_a_max_d;
   logic [PW-1:0] prm_words_q, prm_words_d;
   logic [BW-1:0] batches_q, batches_d;
   logic [PW-1:0] wcnt_q, wcnt_d;
   logic [8:0]    sbeat_q, sbeat_d;
   logic [BW-1:0] sbatch_q, sbatch_d;
   logic [8:0]    dbeat_q, dbeat_d;
   logic [BW-1:0] dbatch_q, dbatch_d;
   logic          last_q, last_d;
   logic          irq_q, irq_d;

   logic          w_accept;
   logic          w_src_beat;
   logic          w_dst_beat;

   assign w_accept   = cfg_valid && (state_q == S_IDLE);
   assign w_src_beat = src_valid && src_ready;
   assign w_dst_beat = dst_valid && dst_ready;

   always_comb begin
      state_d     = state_q;
      out_ch_d    = out_ch_q;
      src_a_max_d = src_a_max_q;
      dst_a_max_d = dst_a_max_q;
      prm_words_d = prm_words_q;
      batches_d   = batches_q;
      wcnt_d      = wcnt_q;
      sbeat_d     = sbeat_q;
      sbatch_d    = sbatch_q;
      dbeat_d     = dbeat_q;
      dbatch_d    = dbatch_q;
      last_d      = last_q;
      irq_d       = irq_q && !irq_clr;

      cfg_ready = (state_q == S_IDLE);
      matw      = (state_q == S_WLOAD);
      run       = (state_q == S_RUN);
      done      = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               out_ch_d    = cfg_out_ch;
               src_a_max_d = cfg_src_a_max;
               dst_a_max_d = cfg_dst_a_max;
               prm_words_d = cfg_prm_words;
               batches_d   = cfg_batches;
               state_d     = (cfg_prm_words != '0) ? S_WLOAD : S_GAP;
            end
         end
         S_WLOAD: begin
            if (w_src_beat) begin
               if (wcnt_q == prm_words_q - PW'(1)) state_d = S_GAP;
               else                                wcnt_d  = wcnt_q + PW'(1);
            end
         end
         S_GAP: state_d = S_RUN;
         S_RUN: begin
            // once last is set, further source beats are a protocol error
            if (w_src_beat && !last_q) begin
               if (sbeat_q == src_a_max_q) begin
                  sbeat_d = '0;
                  if (sbatch_q == batches_q) last_d   = 1'b1;
                  else                       sbatch_d = sbatch_q + BW'(1);
               end else begin
                  sbeat_d = sbeat_q + 9'd1;
               end
            end
            if (w_dst_beat) begin
               if (dbeat_q == dst_a_max_q) begin
                  dbeat_d = '0;
                  if (dbatch_q == batches_q) state_d  = S_DONE;
                  else                       dbatch_d = dbatch_q + BW'(1);
               end else begin
                  dbeat_d = dbeat_q + 9'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!abort) irq_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

      // counters live only inside their own state; leaving it clears them
      if (state_d != S_RUN) begin
         sbeat_d  = '0;
         sbatch_d = '0;
         dbeat_d  = '0;
         dbatch_d = '0;
         last_d   = 1'b0;
      end
      if (state_d != S_WLOAD) wcnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         out_ch_q    <= '0;
         src_a_max_q <= '0;
         dst_a_max_q <= '0;
         prm_words_q <= '0;
         batches_q   <= '0;
         wcnt_q      <= '0;
         sbeat_q     <= '0;
         sbatch_q    <= '0;
         dbeat_q     <= '0;
         dbatch_q    <= '0;
         last_q      <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_ch_q    <= out_ch_d;
         src_a_max_q <= src_a_max_d;
         dst_a_max_q <= dst_a_max_d;
         prm_words_q <= prm_words_d;
         batches_q   <= batches_d;
         wcnt_q      <= wcnt_d;
         sbeat_q     <= sbeat_d;
         sbatch_q    <= sbatch_d;
         dbeat_q     <= dbeat_d;
         dbatch_q    <= dbatch_d;
         last_q      <= last_d;
         irq_q       <= irq_d;
      end
   end

   assign out_ch    = out_ch_q;
   assign src_a_max = src_a_max_q;
   assign dst_a_max = dst_a_max_q;
   assign last      = last_q;
   assign irq       = irq_q;

`ifdef CONV_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (w_accept)                                  perf_d = '0;
      else if ((state_q == S_RUN) && (perf_q != '1)) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_batch_seq.sv
`default_nettype none
// ============================================================================
// tb_conv_batch_seq : directed self-checking bench for conv_batch_seq
// Rev 1.0
// ============================================================================
module tb_conv_batch_seq;

   localparam int BW = 16;
   localparam int PW = 10;

   logic          clk;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [4:0]    cfg_out_ch;
   logic [8:0]    cfg_src_a_max;
   logic [8:0]    cfg_dst_a_max;
   logic [PW-1:0] cfg_prm_words;
   logic [BW-1:0] cfg_batches;
   logic          abort;
   logic [4:0]    out_ch;
   logic [8:0]    src_a_max;
   logic [8:0]    dst_a_max;
   logic          matw;
   logic          run;
   logic          last;
   logic          src_valid;
   logic          src_ready;
   logic          dst_valid;
   logic          dst_ready;
   logic          busy;
   logic          done;
   logic          irq;
   logic          irq_clr;
   logic [31:0]   perf_cycles;

   int n_cmp = 0;
   int n_err = 0;

   conv_batch_seq #(.BW(BW), .PW(PW)) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_out_ch    (cfg_out_ch),
      .cfg_src_a_max (cfg_src_a_max),
      .cfg_dst_a_max (cfg_dst_a_max),
      .cfg_prm_words (cfg_prm_words),
      .cfg_batches   (cfg_batches),
      .abort         (abort),
      .out_ch        (out_ch),
      .src_a_max     (src_a_max),
      .dst_a_max     (dst_a_max),
      .matw          (matw),
      .run           (run),
      .last          (last),
      .src_valid     (src_valid),
      .src_ready     (src_ready),
      .dst_valid     (dst_valid),
      .dst_ready     (dst_ready),
      .busy          (busy),
      .done          (done),
      .irq           (irq),
      .irq_clr       (irq_clr),
      .perf_cycles   (perf_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic command(input logic [4:0] oc, input logic [8:0] sm, input logic [8:0] dm,
                          input logic [PW-1:0] pw, input logic [BW-1:0] nb);
      cfg_out_ch    = oc;
      cfg_src_a_max = sm;
      cfg_dst_a_max = dm;
      cfg_prm_words = pw;
      cfg_batches   = nb;
      cfg_valid     = 1'b1;
      tick();
      cfg_valid     = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cfg_valid = 1'b0; cfg_out_ch = '0; cfg_src_a_max = '0;
      cfg_dst_a_max = '0; cfg_prm_words = '0; cfg_batches = '0; abort = 1'b0;
      src_valid = 1'b0; src_ready = 1'b0; dst_valid = 1'b0; dst_ready = 1'b0;
      irq_clr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // reset / idle
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_matw", matw, 0);
      check("rst_run", run, 0);
      check("rst_last", last, 0);
      check("rst_done", done, 0);
      check("rst_irq", irq, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_src_a_max", src_a_max, 0);
      check("rst_dst_a_max", dst_a_max, 0);
      check("rst_perf", perf_cycles, 0);
      src_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         src_valid = i[0];
         tick();
         check("idle_busy", busy, 0);
         check("idle_ready", cfg_ready, 1);
      end
      src_valid = 1'b0; src_ready = 1'b0;

      // layer A: 4 weight beats, 2 batches of 4 src / 2 dst beats
      command(5'd5, 9'd3, 9'd1, 10'd4, 16'd1);
      check("A_matw_on", matw, 1);
      check("A_out_ch", out_ch, 5);
      check("A_src_a_max", src_a_max, 3);
      check("A_dst_a_max", dst_a_max, 1);
      check("A_cfg_ready", cfg_ready, 0);
      check("A_busy", busy, 1);
      src_valid = 1'b1; src_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("A_matw", matw, 1);
         tick();
      end
      check("A_gap_matw", matw, 0);
      check("A_gap_run", run, 0);
      check("A_gap_busy", busy, 1);
      tick();
      check("A_run_on", run, 1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("A_last", last, 32'(i == 8));
      end
      src_valid = 1'b0; dst_valid = 1'b1; dst_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("A_done", done, 32'(i == 4));
         check("A_run", run, 32'(i != 4));
      end
      check("A_irq_before", irq, 0);
`ifdef CONV_SEQ_PERF_EN
      check("A_perf", perf_cycles, 12);
`else
      check("A_perf", perf_cycles, 0);
`endif
      dst_valid = 1'b0; dst_ready = 1'b0;
      irq_clr = 1'b1;
      tick();
      check("A_irq_set_wins", irq, 1);
      check("A_ready_back", cfg_ready, 1);
      check("A_done_pulse", done, 0);
      tick();
      check("A_irq_cleared", irq, 0);
      irq_clr = 1'b0;
`ifdef CONV_SEQ_PERF_EN
      check("A_perf_hold", perf_cycles, 12);
`endif

      // layer B: no weight phase
      command(5'd2, 9'd0, 9'd0, 10'd0, 16'd0);
      check("B_gap_busy", busy, 1);
      check("B_gap_matw", matw, 0);
      check("B_gap_run", run, 0);
      check("B_out_ch", out_ch, 2);
      tick();
      check("B_run", run, 1);
      check("B_matw", matw, 0);
      src_valid = 1'b1; src_ready = 1'b1;
      tick();
      check("B_last", last, 1);
      src_valid = 1'b0; dst_valid = 1'b1; dst_ready = 1'b1;
      tick();
      check("B_done", done, 1);
      check("B_run_off", run, 0);
      dst_valid = 1'b0;
      tick();
      check("B_irq", irq, 1);
      check("B_ready", cfg_ready, 1);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("B_irq_clr", irq, 0);

      // layer C: 3 batches x 6 dst beats with dst_ready toggling
      command(5'd0, 9'd0, 9'd5, 10'd0, 16'd2);
      tick();
      check("C_run", run, 1);
      dst_valid = 1'b1;
      for (int i = 0; i < 36; i++) begin
         dst_ready = i[0];
         tick();
         check("C_done", done, 32'(i == 35));
      end
      dst_valid = 1'b0; dst_ready = 1'b0;
      tick();
      check("C_irq", irq, 1);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;

      // layer D: abort mid-RUN after last has been set
      command(5'd7, 9'd1, 9'd3, 10'd2, 16'd0);
      src_valid = 1'b1; src_ready = 1'b1;
      tick(); tick();
      check("D_gap_matw", matw, 0);
      tick();
      check("D_run", run, 1);
      tick(); tick();
      check("D_last", last, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      src_valid = 1'b0;
      check("D_abort_run", run, 0);
      check("D_abort_last", last, 0);
      check("D_abort_ready", cfg_ready, 1);
      check("D_abort_busy", busy, 0);
      check("D_abort_done", done, 0);
      tick();
      check("D_no_done", done, 0);
      check("D_no_irq", irq, 0);

      // layer E: completes normally after the abort
      src_valid = 1'b1; src_ready = 1'b1; dst_valid = 1'b1; dst_ready = 1'b1;
      command(5'd1, 9'd0, 9'd0, 10'd1, 16'd0);
      check("E_matw", matw, 1);
      tick();
      check("E_gap_matw", matw, 0);
      check("E_gap_run", run, 0);
      tick();
      check("E_run", run, 1);
      tick();
      check("E_done", done, 1);
      check("E_run_off", run, 0);
      check("E_last_off", last, 0);
      src_valid = 1'b0; dst_valid = 1'b0;
      tick();
      check("E_irq", irq, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("E_idle_abort_irq", irq, 1);
      check("E_idle_abort_ready", cfg_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
